// File: rtl/fft_out_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_out_streamer
//  Description : Snapshots the FFT result bus on each completed transform and
//                streams the bins one per valid/ready handshake, each with an
//                |re|+|im| magnitude estimate. Optional bit-reversed to
//                natural order reordering.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    fft_finish  in   completion level from FFT core (rising edge = new frame)
//    fft_data    in   N packed words, word i = fft_data[i*MSB +: MSB]
//    out_valid   out  bin on out_* is valid
//    out_ready   in   consumer accepts on out_valid & out_ready
//    out_data    out  raw packed bin word {re, im}
//    out_mag     out  unsigned |re|+|im|
//    out_index   out  output position k
//    out_last    out  high with the bin at k == N-1
//    busy        out  frame being loaded or streamed
//    overrun     out  sticky: completion edge arrived while busy
// ============================================================================
module fft_out_streamer #(
    parameter int N       = 16,
    parameter int MSB     = 16,
    parameter int BIT_REV = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fft_finish,
    input  logic [MSB*N-1:0]       fft_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MSB-1:0]         out_data,
    output logic [MSB/2:0]         out_mag,
    output logic [$clog2(N)-1:0]   out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overrun
);

    localparam int LOG2N = $clog2(N);
    localparam int HALF  = MSB / 2;
    localparam int MAGW  = HALF + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               fin_q;
    logic               start;
    logic [MSB*N-1:0]   snap;
    logic               handshake;
    logic               capture;
    logic               present;
    logic               drop;
    logic [LOG2N-1:0]   pos_next;
    logic [LOG2N-1:0]   src_idx;
    logic [MSB-1:0]     src_word;
    logic [MAGW-1:0]    re_ext;
    logic [MAGW-1:0]    im_ext;
    logic [MAGW-1:0]    re_abs;
    logic [MAGW-1:0]    im_abs;
    logic [MAGW-1:0]    mag;

    // Rising edge only: a level held high across frames never re-triggers.
    assign start     = fft_finish & ~fin_q;
    assign handshake = out_valid & out_ready;
    assign busy      = (state != S_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        present    = 1'b0;
        drop       = 1'b0;
        pos_next   = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                present    = 1'b1;
                pos_next   = '0;
                state_next = S_STREAM;
            end
            S_STREAM: begin
                if (handshake) begin
                    if (out_index == LOG2N'(N - 1)) begin
                        drop       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        // Next bin is loaded on the same edge as the
                        // handshake, so out_valid never drops mid-frame.
                        present  = 1'b1;
                        pos_next = out_index + LOG2N'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer address: position k maps to word bitrev(k) or k
    // ------------------------------------------------------------------
    generate
        if (BIT_REV != 0) begin : g_bitrev
            for (genvar b = 0; b < LOG2N; b++) begin : g_bit
                assign src_idx[b] = pos_next[LOG2N-1-b];
            end
        end else begin : g_natural
            assign src_idx = pos_next;
        end
    endgenerate

    assign src_word = snap[int'(src_idx)*MSB +: MSB];

    // One extra bit of headroom makes abs(most-negative) exact and the
    // sum of two halves (max 2^HALF) fit without overflow.
    assign re_ext = {src_word[MSB-1],  src_word[MSB-1:HALF]};
    assign im_ext = {src_word[HALF-1], src_word[HALF-1:0]};
    assign re_abs = re_ext[MAGW-1] ? (MAGW'(0) - re_ext) : re_ext;
    assign im_abs = im_ext[MAGW-1] ? (MAGW'(0) - im_ext) : im_ext;
    assign mag    = re_abs + im_abs;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_q     <= 1'b0;
            snap      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mag   <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            fin_q <= fft_finish;
            if (capture) begin
                snap <= fft_data;
            end
            if (present) begin
                out_valid <= 1'b1;
                out_data  <= src_word;
                out_mag   <= mag;
                out_index <= pos_next;
                out_last  <= (pos_next == LOG2N'(N - 1));
            end else if (drop) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            // A new frame edge while busy is dropped; the stream in
            // flight is left untouched.
            if (start && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
